seq_mul16_ctrl: RTL and testbench
=================================

SEQ_MUL16_CTRL -- requirements
Module: seq_mul16_ctrl

Interface
REQ-001 Parameters: none; the block is fixed at 16x16 unsigned operands and a 32-bit product.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  operand pair a/b presented.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 a  input  16  unsigned multiplicand.
REQ-007 b  input  16  unsigned multiplier.
REQ-008 out_valid  output  1  product valid.
REQ-009 out_ready  input  1  consumer takes the product.
REQ-010 product  output  32  unsigned a*b, registered.

Function
REQ-011 The block SHALL compute a 16x16 product by time-sharing one 8x8 multiplier over four steps, with accumulation into a 32-bit register.
REQ-012 States SHALL be IDLE, MUL and DONE; step counter is 2 bits, used only in MUL.
REQ-013 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-014 Accept occurs when in_valid && in_ready at an edge; on that edge: latch a/b, clear accumulator, step=0, IDLE->MUL.
REQ-015 Step order and shifts: 0 = a[7:0]*b[7:0] <<0; 1 = a[15:8]*b[7:0] <<8; 2 = a[7:0]*b[15:8] <<8; 3 = a[15:8]*b[15:8] <<16.
REQ-016 Each MUL cycle SHALL add the shifted 16-bit partial to the accumulator; step increments; the step-3 edge moves MUL->DONE.
REQ-017 Latency: out_valid SHALL rise exactly 4 cycles after the accept edge.
REQ-018 Arithmetic: unsigned, 32-bit accumulator; no intermediate or final overflow is possible, so no carry-out exists.
REQ-019 In DONE, product and out_valid SHALL hold stable until out_valid && out_ready at an edge, which moves DONE->IDLE.
REQ-020 in_valid and a/b SHALL be ignored outside IDLE; operand changes after accept SHALL NOT affect the result.
REQ-021 Back-to-back: minimum accept-to-accept period is 6 cycles (4 compute, 1 DONE handshake, 1 IDLE).
REQ-022 product SHALL show the accumulator at all times; it is valid only while out_valid=1.

Reset
REQ-023 rst_n low SHALL immediately force state=IDLE, step=0, accumulator/product=0, out_valid=0, in_ready=1 (after async assert), at any point including mid-MUL or in DONE.
REQ-024 After rst_n deasserts, the first accept SHALL behave identically to a fresh power-up.

Configuration
REQ-025 Macro SEQMUL_ZERO_SKIP_EN: when defined, accepting an operand pair with a==0 or b==0 SHALL go IDLE->DONE with product=0, so out_valid rises 1 cycle after accept.
REQ-026 Without SEQMUL_ZERO_SKIP_EN, zero operands SHALL take the normal 4-step path (latency 4, product 0).

Structure
REQ-027 Shared package seq_mul_pkg SHALL hold the state enum (IDLE/MUL/DONE), the step-index width, the operand width (16) and the product width (32).
REQ-028 The single sub-module is the team's existing 8x8 unsigned multiplier, WallaceMultiplier8Bit, instantiated once; operand select muxes and the shift/add stay in seq_mul16_ctrl.

Verification
REQ-029 a=0xFFFF, b=0xFFFF accepted, out_ready=1 -> out_valid 4 cycles after accept, product=0xFFFE0001.
REQ-030 a=0x1234, b=0x5678 -> product=0x06260060; a/b changed to 0xAAAA during MUL does not alter result.
REQ-031 Result 0x06260060 with out_ready held 0 for 3 cycles -> product/out_valid stable, in_ready=0, in_valid pulses ignored; handshake then returns to IDLE.
REQ-032 rst_n pulsed low during step 2 -> out_valid=0, product=0, in_ready=1; next pair 0x0003*0x0005 -> 0x0000000F at latency 4.
REQ-033 a=0x0000, b=0xBEEF -> product=0; latency 1 with SEQMUL_ZERO_SKIP_EN, 4 without.
REQ-034 in_valid held 1, out_ready=1, five random pairs -> accepts exactly every 6 cycles; each product matches a*b.

Source files
------------

// File: rtl/seq_mul_pkg.sv
// seq_mul_pkg
// Shared types and widths for the sequential 16x16 multiplier controller.
//   state_t   : controller states (IDLE / MUL / DONE)
//   STEP_W    : width of the partial-product step index
//   OP_W      : operand width
//   PROD_W    : product / accumulator width
package seq_mul_pkg;

  localparam int STEP_W = 2;
  localparam int OP_W   = 16;
  localparam int PROD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mul16_ctrl_wallace8.sv
// WallaceMultiplier8Bit
// Combinational 8x8 unsigned multiplier shared by the sequential controller.
// Ports:
//   a [7:0]  in   multiplicand
//   b [7:0]  in   multiplier
//   p [15:0] out  a*b
module WallaceMultiplier8Bit (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  // Partial-product rows; the synthesis tool builds the reduction tree.
  logic [15:0] rows [8];

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      rows[i] = b[i] ? (16'(a) << i) : 16'h0000;
    end
  end

  always_comb begin
    p = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      p = p + rows[i];
    end
  end

endmodule

// File: rtl/seq_mul16_ctrl.sv
// seq_mul16_ctrl
// 16x16 unsigned multiplier that time-shares one 8x8 multiplier over four
// steps, accumulating shifted partial products into a 32-bit register.
// Ready/valid handshake on both sides.
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand pair presented
//   in_ready   out  accepting operands (IDLE only)
//   a, b [15:0] in  unsigned operands
//   out_valid  out  product valid (DONE only)
//   out_ready  in   consumer takes the product
//   product [31:0] out  accumulator, valid while out_valid=1
// Build option: SEQMUL_ZERO_SKIP_EN -- a zero operand skips straight to DONE
// with product 0 (latency 1 instead of 4).
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready=1
// MUL   | one 8x8 partial per cycle, step 0..3
// DONE  | product held until out_ready, out_valid=1
module seq_mul16_ctrl
  import seq_mul_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] product
);

  state_t              state, state_nxt;
  logic [STEP_W-1:0]   step;
  logic [OP_W-1:0]     a_q, b_q;
  logic [PROD_W-1:0]   acc;
  logic                accept;
  logic                zero_op;
  logic [7:0]          mul_a, mul_b;
  logic [15:0]         partial;
  logic [4:0]          shift_amt;

`ifdef SEQMUL_ZERO_SKIP_EN
  assign zero_op = (a == '0) || (b == '0);
`else
  assign zero_op = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = zero_op ? DONE : MUL;
        end
      end
      MUL: begin
        if (step == STEP_W'(3)) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // step[0] picks the high byte of a, step[1] the high byte of b, giving the
  // order lo*lo, hi*lo, lo*hi, hi*hi.
  assign mul_a = step[0] ? a_q[15:8] : a_q[7:0];
  assign mul_b = step[1] ? b_q[15:8] : b_q[7:0];

  always_comb begin
    case (step)
      2'd0:    shift_amt = 5'd0;
      2'd3:    shift_amt = 5'd16;
      default: shift_amt = 5'd8;
    endcase
  end

  WallaceMultiplier8Bit u_mul8 (
    .a (mul_a),
    .b (mul_b),
    .p (partial)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step <= '0;
      a_q  <= '0;
      b_q  <= '0;
      acc  <= '0;
    end else if (accept) begin
      step <= '0;
      a_q  <= a;
      b_q  <= b;
      acc  <= '0;
    end else if (state == MUL) begin
      step <= step + STEP_W'(1);
      acc  <= acc + (PROD_W'(partial) << shift_amt);
    end
  end

  assign product = acc;

endmodule

// File: tb/tb_seq_mul16_ctrl.sv
module tb_seq_mul16_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] product;

  int n_checks = 0;
  int n_fail   = 0;

  seq_mul16_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  always #5 clk = ~clk;

  function automatic int exp_latency(input logic [15:0] xa, input logic [15:0] xb);
`ifdef SEQMUL_ZERO_SKIP_EN
    if (xa == 0 || xb == 0) return 1;
`endif
    return 4;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a pair, count cycles from the accept edge to out_valid, check
  // latency and value; leaves the DUT in DONE.
  task automatic start_and_wait(input logic [15:0] xa, input logic [15:0] xb,
                                input string name, input bit scramble);
    logic [31:0] exp_p;
    int lat;
    int guard;
    exp_p = 32'(xa) * 32'(xb);
    in_valid = 1'b1;
    a = xa;
    b = xb;
    guard = 0;
    while (!in_ready && guard < 20) begin tick(); guard++; end
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (scramble) begin a = 16'hAAAA; b = 16'hAAAA; end
      else begin a = 16'($urandom); b = 16'($urandom); end
      tick();
      lat++;
    end
    n_checks++;
    if (lat !== exp_latency(xa, xb)) begin
      n_fail++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_latency(xa, xb));
    end
    n_checks++;
    if (product !== exp_p) begin
      n_fail++;
      $display("FAIL %s product: got %h expected %h", name, product, exp_p);
    end
  endtask

  task automatic finish_handshake(input string name);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s return_idle: got in_ready=%b out_valid=%b expected 1/0",
               name, in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 32'h0) begin
      n_fail++;
      $display("FAIL reset: got in_ready=%b out_valid=%b product=%h expected 1/0/0",
               in_ready, out_valid, product);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_max();
    start_and_wait(16'hFFFF, 16'hFFFF, "max", 1'b0);
    n_checks++;
    if (product !== 32'hFFFE0001) begin
      n_fail++;
      $display("FAIL max_const: got %h expected fffe0001", product);
    end
    finish_handshake("max");
  endtask

  task automatic test_operand_change();
    start_and_wait(16'h1234, 16'h5678, "opchg", 1'b1);
    n_checks++;
    if (product !== 32'h06260060) begin
      n_fail++;
      $display("FAIL opchg_const: got %h expected 06260060", product);
    end
    finish_handshake("opchg");
  endtask

  task automatic test_stall();
    start_and_wait(16'h1234, 16'h5678, "stall", 1'b0);
    for (int i = 0; i < 3; i++) begin
      in_valid = i[0] ? 1'b0 : 1'b1;
      a = 16'h0001;
      b = 16'h0001;
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || product !== 32'h06260060 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got ov=%b product=%h ir=%b expected 1/06260060/0",
                 i, out_valid, product, in_ready);
      end
    end
    in_valid = 1'b0;
    finish_handshake("stall");
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1;
    a = 16'h4321;
    b = 16'h8765;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || product !== 32'h0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid: got ov=%b product=%h ir=%b expected 0/0/1",
               out_valid, product, in_ready);
    end
    #2;
    rst_n = 1'b1;
    tick();
    start_and_wait(16'h0003, 16'h0005, "post_reset", 1'b0);
    finish_handshake("post_reset");
  endtask

  task automatic test_zero();
    start_and_wait(16'h0000, 16'hBEEF, "zero_a", 1'b0);
    finish_handshake("zero_a");
    start_and_wait(16'h7777, 16'h0000, "zero_b", 1'b0);
    finish_handshake("zero_b");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      start_and_wait(16'($urandom), 16'($urandom), "random", 1'b0);
      finish_handshake("random");
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    int acc_cyc[$];
    int cyc;
    int n_acc;
    int n_done;
    bit just_acc;
    n_acc = 0;
    n_done = 0;
    cyc = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    a = 16'($urandom_range(1, 65535));
    b = 16'($urandom_range(1, 65535));
    while (n_done < 5 && cyc < 100) begin
      just_acc = 1'b0;
      if (out_valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_extra: got product %h expected none", product);
        end else begin
          if (product !== exp_q[0]) begin
            n_fail++;
            $display("FAIL b2b_product%0d: got %h expected %h", n_done, product, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        n_done++;
      end
      if (in_ready && in_valid) begin
        exp_q.push_back(32'(a) * 32'(b));
        acc_cyc.push_back(cyc);
        n_acc++;
        just_acc = 1'b1;
      end
      tick();
      cyc++;
      if (just_acc) begin
        if (n_acc == 5) in_valid = 1'b0;
        a = 16'($urandom_range(1, 65535));
        b = 16'($urandom_range(1, 65535));
      end
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (n_done != 5 || acc_cyc.size() != 5) begin
      n_fail++;
      $display("FAIL b2b_count: got accepts=%0d products=%0d expected 5/5",
               acc_cyc.size(), n_done);
    end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      n_checks++;
      if (acc_cyc[i] - acc_cyc[i-1] != 6) begin
        n_fail++;
        $display("FAIL b2b_period%0d: got %0d expected 6", i, acc_cyc[i] - acc_cyc[i-1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_max();
    test_operand_change();
    test_stall();
    test_reset_mid();
    test_zero();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
